model_matrix_activation_function: RTL and testbench
===================================================

MODEL_MATRIX_ACTIVATION_FUNCTION -- requirements
Module: model_matrix_activation_function

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64: width in bits of the data and size ports.
REQ-002 SHALL have parameter CONTROL_SIZE, default 64: width in bits of the internal row and column index counters.
REQ-003 SHALL have parameter FRAC_SIZE, default 16: number of fractional bits of the signed two's-complement fixed-point data; ONE = 2^FRAC_SIZE, HALF = 2^(FRAC_SIZE-1).
REQ-004 SHALL have port CLK, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port START, input, 1 bit: begins a matrix pass when the block is idle.
REQ-007 SHALL have port READY, output, 1 bit: one-cycle pulse issued with the last output element of a pass.
REQ-008 SHALL have port MODE, input, 2 bits: activation select; 0 = hard-tanh, 1 = hard-logistic, 2 = ReLU, 3 = identity.
REQ-009 SHALL have port SIZE_I_IN, input, DATA_SIZE bits: number of rows.
REQ-010 SHALL have port SIZE_J_IN, input, DATA_SIZE bits: number of columns.
REQ-011 SHALL have port DATA_IN_I_ENABLE, input, 1 bit: qualifies DATA_IN as the first element of a row.
REQ-012 SHALL have port DATA_IN_J_ENABLE, input, 1 bit: qualifies DATA_IN as a subsequent element within a row.
REQ-013 SHALL have port DATA_IN, input, DATA_SIZE bits: input element.
REQ-014 SHALL have port DATA_OUT, output, DATA_SIZE bits: result element.
REQ-015 SHALL have port DATA_OUT_J_ENABLE, output, 1 bit: one-cycle strobe marking each valid DATA_OUT.
REQ-016 SHALL have port DATA_OUT_I_ENABLE, output, 1 bit: one-cycle strobe coincident with DATA_OUT_J_ENABLE on the last element of each row.

Function
REQ-017 SHALL implement the FSM states STARTER, INPUT_I, INPUT_J, COMPUTE and ENDER.
REQ-018 In STARTER, when START=1, the block SHALL latch SIZE_I_IN, SIZE_J_IN and MODE, clear i and j, and go to INPUT_I.
REQ-019 If either latched size is 0, the block SHALL instead pulse READY for one cycle with no data strobes and remain in STARTER.
REQ-020 In INPUT_I, the block SHALL capture DATA_IN when DATA_IN_I_ENABLE=1 and go to COMPUTE; DATA_IN_J_ENABLE SHALL be ignored in this state, including when both enables are asserted together.
REQ-021 In INPUT_J, the block SHALL capture DATA_IN when DATA_IN_J_ENABLE=1 and go to COMPUTE; DATA_IN_I_ENABLE SHALL be ignored in this state.
REQ-022 In COMPUTE, the block SHALL register f(x) for the latched MODE and go to ENDER, taking exactly one cycle.
REQ-023 In ENDER, the block SHALL register DATA_OUT = f(x) and assert DATA_OUT_J_ENABLE for exactly one cycle.
REQ-024 In ENDER, when j = SJ-1, the block SHALL also assert DATA_OUT_I_ENABLE.
REQ-025 In ENDER, when i = SI-1 and j = SJ-1, the block SHALL also assert READY and go to STARTER.
REQ-026 In ENDER, when j = SJ-1 and i < SI-1, the block SHALL set i = i+1, j = 0 and go to INPUT_I.
REQ-027 In ENDER, when j < SJ-1, the block SHALL set j = j+1 and go to INPUT_J.
REQ-028 Latency: for an element sampled at edge k, the output strobes SHALL be high from edge k+2 to edge k+3; the earliest next acceptance SHALL be edge k+3, giving a throughput of one element per 3 cycles.
REQ-029 Hard-tanh SHALL produce ONE if x >= ONE, -ONE if x <= -ONE, and x otherwise.
REQ-030 Hard-logistic SHALL produce ONE if x >= 2*ONE, 0 if x <= -2*ONE, and (x >>> 2) + HALF otherwise, using an arithmetic shift; it SHALL never overflow.
REQ-031 ReLU SHALL produce x if x > 0 and 0 otherwise; identity SHALL produce x.
REQ-032 DATA_OUT SHALL hold its last value between strobes.
REQ-033 START SHALL be ignored outside STARTER, and MODE and size changes during a pass SHALL be ignored.
REQ-034 Input enables received in STARTER, COMPUTE or ENDER SHALL be dropped.

Reset
REQ-035 While RST=1, the block SHALL hold READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE and DATA_OUT at 0, i and j at 0, and the FSM in STARTER.
REQ-036 Reset asserted mid-pass SHALL abort the pass with no further strobes; after release, the block SHALL wait for a new START.

Verification (FRAC_SIZE=16, ONE=0x10000)
REQ-037 The bench SHALL run MODE=0, 2x2, inputs {0x8000, 0x30000, -0x30000, 0} -> outputs {0x8000, 0x10000, -0x10000, 0}; DATA_OUT_I_ENABLE on elements 2 and 4; READY only on element 4.
REQ-038 The bench SHALL run MODE=1, 1x3, inputs {0, 0x40000, 0x10000} -> outputs {0x8000, 0x10000, 0xC000}.
REQ-039 The bench SHALL run MODE=2, 1x2, inputs {-5, 7} -> outputs {0, 7}; each strobe appears exactly 2 edges after the accepting edge.
REQ-040 The bench SHALL run START with SIZE_I_IN=0 -> a single READY pulse and no data strobes.
REQ-041 The bench SHALL assert DATA_IN_I_ENABLE and DATA_IN_J_ENABLE together in INPUT_I, and issue a second START mid-pass -> the element is accepted once as a row start and the second START has no effect.
REQ-042 The bench SHALL assert RST after the 2nd element of a 3x3 pass -> outputs are 0 immediately; a subsequent 1x1 identity pass with input 0x1234 -> DATA_OUT=0x1234 with READY, DATA_OUT_I_ENABLE and DATA_OUT_J_ENABLE all asserted.

Source files
------------

// File: rtl/model_matrix_activation_function.sv
// Element-wise activation over a streamed matrix of signed fixed-point values.
// Elements arrive one at a time: a row-start strobe, then in-row strobes.
// Each accepted element comes out two edges later, with row-end and pass-end flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// STARTER | idle; waits for START, then latches the sizes and the mode
// INPUT_I | waits for the first element of a row (DATA_IN_I_ENABLE)
// INPUT_J | waits for the next element in a row (DATA_IN_J_ENABLE)
// COMPUTE | applies the activation to the captured element
// ENDER   | presents the result and advances the row/column indices
module model_matrix_activation_function #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRAC_SIZE    = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [1:0]           MODE,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic                 DATA_IN_I_ENABLE,
  input  logic                 DATA_IN_J_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_I_ENABLE
);

  typedef enum logic [2:0] {
    STARTER = 3'd0,
    INPUT_I = 3'd1,
    INPUT_J = 3'd2,
    COMPUTE = 3'd3,
    ENDER   = 3'd4
  } state_t;

  localparam logic signed [DATA_SIZE-1:0] ONE     = DATA_SIZE'(1) << FRAC_SIZE;
  localparam logic signed [DATA_SIZE-1:0] NEG_ONE = -ONE;
  localparam logic signed [DATA_SIZE-1:0] TWO     = ONE <<< 1;
  localparam logic signed [DATA_SIZE-1:0] NEG_TWO = -TWO;
  localparam logic signed [DATA_SIZE-1:0] HALF    = ONE >>> 1;
  localparam logic signed [DATA_SIZE-1:0] ZERO    = '0;

  localparam logic [DATA_SIZE-1:0]    DATA_ONE = DATA_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] CTRL_ONE = CONTROL_SIZE'(1);

  state_t                  state_q, state_d;
  logic [DATA_SIZE-1:0]    size_i_q, size_i_d;
  logic [DATA_SIZE-1:0]    size_j_q, size_j_d;
  logic [1:0]              mode_q, mode_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] j_q, j_d;
  logic [DATA_SIZE-1:0]    x_q, x_d;
  logic [DATA_SIZE-1:0]    y_q, y_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    out_i_en_q, out_i_en_d;
  logic                    out_j_en_q, out_j_en_d;

  logic last_i, last_j, size_zero;

  // Logistic is only evaluated strictly inside (-2, 2), so (x >>> 2) + HALF
  // lands in (0, 1) and cannot overflow.
  function automatic logic [DATA_SIZE-1:0] activate(input logic [1:0] m,
                                                    input logic signed [DATA_SIZE-1:0] x);
    logic signed [DATA_SIZE-1:0] r;
    r = x;
    case (m)
      2'd0: begin
        if (x >= ONE)          r = ONE;
        else if (x <= NEG_ONE) r = NEG_ONE;
        else                   r = x;
      end
      2'd1: begin
        if (x >= TWO)          r = ONE;
        else if (x <= NEG_TWO) r = ZERO;
        else                   r = (x >>> 2) + HALF;
      end
      2'd2:    r = (x > ZERO) ? x : ZERO;
      default: r = x;
    endcase
    return r;
  endfunction

  assign last_i    = (DATA_SIZE'(i_q) == (size_i_q - DATA_ONE));
  assign last_j    = (DATA_SIZE'(j_q) == (size_j_q - DATA_ONE));
  assign size_zero = (SIZE_I_IN == '0) || (SIZE_J_IN == '0);

  // State and datapath registers with asynchronous active-high reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= STARTER;
      size_i_q   <= '0;
      size_j_q   <= '0;
      mode_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      out_i_en_q <= 1'b0;
      out_j_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_i_q   <= size_i_d;
      size_j_q   <= size_j_d;
      mode_q     <= mode_d;
      i_q        <= i_d;
      j_q        <= j_d;
      x_q        <= x_d;
      y_q        <= y_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      out_i_en_q <= out_i_en_d;
      out_j_en_q <= out_j_en_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      STARTER: if (START) state_d = size_zero ? STARTER : INPUT_I;
      INPUT_I: if (DATA_IN_I_ENABLE) state_d = COMPUTE;
      INPUT_J: if (DATA_IN_J_ENABLE) state_d = COMPUTE;
      COMPUTE: state_d = ENDER;
      ENDER: begin
        if (last_j && last_i) state_d = STARTER;
        else if (last_j)      state_d = INPUT_I;
        else                  state_d = INPUT_J;
      end
      default: state_d = STARTER;
    endcase
  end

  // Per-state datapath updates and registered output strobes
  always_comb begin
    size_i_d   = size_i_q;
    size_j_d   = size_j_q;
    mode_d     = mode_q;
    i_d        = i_q;
    j_d        = j_q;
    x_d        = x_q;
    y_d        = y_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    out_i_en_d = 1'b0;
    out_j_en_d = 1'b0;
    case (state_q)
      STARTER: begin
        if (START) begin
          size_i_d = SIZE_I_IN;
          size_j_d = SIZE_J_IN;
          mode_d   = MODE;
          i_d      = '0;
          j_d      = '0;
          ready_d  = size_zero;
        end
      end
      INPUT_I: if (DATA_IN_I_ENABLE) x_d = DATA_IN;
      INPUT_J: if (DATA_IN_J_ENABLE) x_d = DATA_IN;
      COMPUTE: y_d = activate(mode_q, x_q);
      ENDER: begin
        data_out_d = y_q;
        out_j_en_d = 1'b1;
        out_i_en_d = last_j;
        ready_d    = last_j && last_i;
        if (last_j && !last_i) begin
          i_d = i_q + CTRL_ONE;
          j_d = '0;
        end else if (!last_j) begin
          j_d = j_q + CTRL_ONE;
        end
      end
      default: ;
    endcase
  end

  assign READY             = ready_q;
  assign DATA_OUT          = data_out_q;
  assign DATA_OUT_I_ENABLE = out_i_en_q;
  assign DATA_OUT_J_ENABLE = out_j_en_q;

endmodule

// File: tb/tb_model_matrix_activation_function.sv
// Bench for model_matrix_activation_function: directed vector table, reset
// abort sequence, then randomized passes against an arithmetic reference.
module tb_model_matrix_activation_function;

  localparam longint ONE = 65536;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY;
  logic [1:0]  MODE = '0;
  logic [63:0] SIZE_I_IN = '0;
  logic [63:0] SIZE_J_IN = '0;
  logic        DATA_IN_I_ENABLE = 1'b0;
  logic        DATA_IN_J_ENABLE = 1'b0;
  logic [63:0] DATA_IN = '0;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_J_ENABLE;
  logic        DATA_OUT_I_ENABLE;

  model_matrix_activation_function dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .MODE(MODE),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
    .DATA_IN_I_ENABLE(DATA_IN_I_ENABLE), .DATA_IN_J_ENABLE(DATA_IN_J_ENABLE),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE), .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    bit          j;
    bit          i;
    bit          r;
    int          edge_n;
  } ev_t;

  typedef struct {
    logic [1:0]  mode;
    int          si;
    int          sj;
    logic [63:0] din[4];
    logic [63:0] dout[4];
    bit          both_en;
  } vec_t;

  ev_t         act_q[$];
  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] last_out = '0;
  logic [63:0] prev_out = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every strobe with the edge it followed; check DATA_OUT holds otherwise
  always begin
    ev_t ev;
    @(posedge CLK);
    #2;
    if (DATA_OUT_J_ENABLE || DATA_OUT_I_ENABLE || READY) begin
      ev.data = DATA_OUT; ev.j = DATA_OUT_J_ENABLE; ev.i = DATA_OUT_I_ENABLE;
      ev.r = READY; ev.edge_n = cyc;
      act_q.push_back(ev);
    end
    if (!RST && !DATA_OUT_J_ENABLE) begin
      checks++;
      if (DATA_OUT !== prev_out) begin
        errors++;
        $display("FAIL hold at edge %0d: DATA_OUT=%h, required to stay %h", cyc, DATA_OUT, prev_out);
      end
    end
    prev_out = DATA_OUT;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_act(input logic [1:0] m, input logic [63:0] xin);
    longint x;
    longint q;
    x = xin;
    case (m)
      2'd0: return (x >= ONE) ? ONE : ((x <= -ONE) ? -ONE : x);
      2'd1: begin
        if (x >= 2 * ONE) return ONE;
        if (x <= -2 * ONE) return 0;
        q = (x >= 0) ? (x / 4) : -((-x + 3) / 4);  // floor(x/4)
        return q + ONE / 2;
      end
      2'd2: return (x > 0) ? x : 0;
      default: return x;
    endcase
  endfunction

  function automatic logic [63:0] pick_value();
    longint edges[10];
    edges = '{ONE, -ONE, 2*ONE, -2*ONE, ONE-1, -ONE+1, 2*ONE-1, -2*ONE+1, 0, -1};
    case ($urandom_range(0, 4))
      0: return edges[$urandom_range(0, 9)];
      1: return longint'($urandom_range(0, 6 * 65536)) - 3 * ONE;
      2: return {$urandom, $urandom};
      3: return longint'($urandom_range(0, 16)) - 8;
      default: return longint'($urandom_range(0, 65536)) - 32768;
    endcase
  endfunction

  function automatic void push_exp(input logic [63:0] d, input bit j, input bit i,
                                   input bit r, input int e);
    ev_t ev;
    ev.data = d; ev.j = j; ev.i = i; ev.r = r; ev.edge_n = e;
    exp_q.push_back(ev);
  endfunction

  task automatic check_events(input string name);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d strobe events, required %0d", name, act_q.size(), exp_q.size());
    end
    for (int k = 0; k < act_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (act_q[k].data !== exp_q[k].data || act_q[k].j != exp_q[k].j ||
          act_q[k].i != exp_q[k].i || act_q[k].r != exp_q[k].r ||
          act_q[k].edge_n != exp_q[k].edge_n) begin
        errors++;
        $display("FAIL %s ev%0d: got data=%h j=%0d i=%0d rdy=%0d edge=%0d, required data=%h j=%0d i=%0d rdy=%0d edge=%0d",
                 name, k, act_q[k].data, act_q[k].j, act_q[k].i, act_q[k].r, act_q[k].edge_n,
                 exp_q[k].data, exp_q[k].j, exp_q[k].i, exp_q[k].r, exp_q[k].edge_n);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_junk(input bit noisy, input bit allow_i, input bit allow_j);
    DATA_IN          = noisy ? {$urandom, $urandom} : 64'd0;
    DATA_IN_I_ENABLE = noisy && allow_i && ($urandom_range(0, 1) == 1);
    DATA_IN_J_ENABLE = noisy && allow_j && ($urandom_range(0, 1) == 1);
    START            = noisy && ($urandom_range(0, 1) == 1);
    if (noisy) begin
      MODE = 2'($urandom);
      SIZE_I_IN = 64'($urandom_range(0, 5));
      SIZE_J_IN = 64'($urandom_range(0, 5));
    end
  endtask

  // Start a pass, feed n_feed elements at the earliest acceptance points (plus
  // random gaps and dropped-enable noise when noisy), and queue expected strobes.
  task automatic run_pass(input logic [1:0] m, input int si, input int sj, input int n_feed,
                          input logic [63:0] din[16], input logic [63:0] dout[16],
                          input bit both_en, input bit noisy);
    int  acc;
    int  total;
    bit  row_start;
    @(negedge CLK);
    START = 1'b1; MODE = m; SIZE_I_IN = 64'(si); SIZE_J_IN = 64'(sj);
    acc = cyc + 1;
    if (si == 0 || sj == 0) begin
      push_exp(last_out, 1'b0, 1'b0, 1'b1, acc);
      @(negedge CLK);
      START = 1'b0;
      repeat (3) @(negedge CLK);
      return;
    end
    @(negedge CLK);
    drive_junk(noisy, 1'b0, 1'b0);
    total = si * sj;
    for (int e = 0; e < n_feed; e++) begin
      row_start = (e % sj) == 0;
      if (noisy) begin
        repeat ($urandom_range(0, 2)) begin
          drive_junk(1'b1, !row_start, row_start);
          @(negedge CLK);
        end
      end
      DATA_IN          = din[e];
      DATA_IN_I_ENABLE = row_start;
      DATA_IN_J_ENABLE = !row_start || both_en;
      START            = both_en || (noisy && $urandom_range(0, 1) == 1);
      acc = cyc + 1;
      push_exp(dout[e], 1'b1, (e % sj) == sj - 1, e == total - 1, acc + 2);
      last_out = dout[e];
      @(negedge CLK);
      repeat (2) begin
        drive_junk(noisy, 1'b1, 1'b1);
        if (both_en) START = 1'b1;
        @(negedge CLK);
      end
      DATA_IN_I_ENABLE = 1'b0;
      DATA_IN_J_ENABLE = 1'b0;
      START            = 1'b0;
    end
    if (n_feed == total) @(negedge CLK);
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (DATA_OUT !== 64'd0 || READY !== 1'b0 || DATA_OUT_I_ENABLE !== 1'b0 || DATA_OUT_J_ENABLE !== 1'b0) begin
      errors++;
      $display("FAIL %s: got DATA_OUT=%h rdy=%b i=%b j=%b, required all zero",
               name, DATA_OUT, READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE);
    end
  endtask

  initial begin
    vec_t        vecs[5];
    logic [63:0] din[16];
    logic [63:0] dout[16];
    logic [1:0]  m;
    int          si, sj;

    vecs[0] = '{2'd0, 2, 2, '{64'h8000, 64'h30000, -64'sh30000, 64'h0},
                '{64'h8000, 64'h10000, -64'sh10000, 64'h0}, 1'b0};
    vecs[1] = '{2'd1, 1, 3, '{64'h0, 64'h40000, 64'h10000, 64'h0},
                '{64'h8000, 64'h10000, 64'hC000, 64'h0}, 1'b0};
    vecs[2] = '{2'd2, 1, 2, '{-64'sd5, 64'd7, 64'h0, 64'h0},
                '{64'd0, 64'd7, 64'h0, 64'h0}, 1'b0};
    vecs[3] = '{2'd3, 0, 2, '{64'h0, 64'h0, 64'h0, 64'h0},
                '{64'h0, 64'h0, 64'h0, 64'h0}, 1'b0};
    vecs[4] = '{2'd3, 2, 2, '{64'h11, 64'h22, 64'h33, 64'h44},
                '{64'h11, 64'h22, 64'h33, 64'h44}, 1'b1};

    repeat (3) @(negedge CLK);
    check_zero_outputs("reset_state");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      din = '{default: 64'h0};
      dout = '{default: 64'h0};
      for (int e = 0; e < 4; e++) begin
        din[e] = vecs[v].din[e];
        dout[e] = vecs[v].dout[e];
      end
      run_pass(vecs[v].mode, vecs[v].si, vecs[v].sj, vecs[v].si * vecs[v].sj,
               din, dout, vecs[v].both_en, 1'b0);
      check_events($sformatf("vec%0d", v));
    end

    // Reset right after the second element of a 3x3 pass
    din = '{default: 64'h0};
    dout = '{default: 64'h0};
    din[0] = 64'h5000; dout[0] = 64'h5000;
    din[1] = 64'h6000; dout[1] = 64'h6000;
    run_pass(2'd3, 3, 3, 2, din, dout, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check_zero_outputs("reset_mid_pass");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    last_out = '0;
    check_events("pre_reset_elems");
    repeat (4) begin
      DATA_IN = 64'hDEAD; DATA_IN_I_ENABLE = 1'b1; DATA_IN_J_ENABLE = 1'b1;
      @(negedge CLK);
    end
    DATA_IN_I_ENABLE = 1'b0; DATA_IN_J_ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    check_events("post_reset_idle");
    din[0] = 64'h1234; dout[0] = 64'h1234;
    run_pass(2'd3, 1, 1, 1, din, dout, 1'b0, 1'b0);
    check_events("identity_1x1");

    for (int p = 0; p < 25; p++) begin
      m  = 2'($urandom_range(0, 3));
      si = $urandom_range(0, 3);
      sj = $urandom_range(1, 3);
      din = '{default: 64'h0};
      dout = '{default: 64'h0};
      for (int e = 0; e < si * sj; e++) begin
        din[e]  = pick_value();
        dout[e] = ref_act(m, din[e]);
      end
      run_pass(m, si, sj, si * sj, din, dout, $urandom_range(0, 1) == 1, 1'b1);
      check_events($sformatf("rand%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
